// File: rtl/ex_mdu_pkg.sv
// Shared encodings for the M-extension execute unit: funct3 opcodes, FSM
// states and small opcode classification helpers.
package ex_mdu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } md_state_e;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } md_op_e;

  function automatic logic op_is_div(input md_op_e op);
    return op[2];
  endfunction

  function automatic logic op_is_rem(input md_op_e op);
    return op[2] & op[1];
  endfunction

  function automatic logic op_a_signed(input md_op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  // MULHSU keeps B unsigned, so only MULH/DIV/REM sign-extend the divisor/multiplier.
  function automatic logic op_b_signed(input md_op_e op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/ex_mdu_iter.sv
// md_iter: radix-2 iterative datapath shared by multiply (shift-add) and
// divide (restoring), plus the iteration counter.
module md_iter
  import ex_mdu_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned CW   = $clog2(XLEN + 1)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            i_load,
  input  logic            i_div,
  input  logic            i_step,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_hi_nxt,
  output logic [XLEN-1:0] o_lo_nxt,
  output logic [CW-1:0]   o_cnt
);

  logic            r_div;
  logic [XLEN-1:0] r_opd;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [CW-1:0]   r_cnt;

  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_trial;

  // r_hi:r_lo is the 2*XLEN product for multiply, remainder:quotient for divide.
  always_comb begin
    w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opd} : '0);
    w_shift = {r_hi, r_lo[XLEN-1]};
    w_trial = w_shift - {1'b0, r_opd};
    o_hi_nxt = '0;
    o_lo_nxt = '0;
    if (r_div) begin
      if (!w_trial[XLEN]) begin
        o_hi_nxt = w_trial[XLEN-1:0];
        o_lo_nxt = {r_lo[XLEN-2:0], 1'b1};
      end else begin
        o_hi_nxt = w_shift[XLEN-1:0];
        o_lo_nxt = {r_lo[XLEN-2:0], 1'b0};
      end
    end else begin
      o_hi_nxt = w_sum[XLEN:1];
      o_lo_nxt = {w_sum[0], r_lo[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_div <= 1'b0;
      r_opd <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_div <= i_div;
      r_hi  <= '0;
      r_lo  <= i_div ? i_a : i_b;
      r_opd <= i_div ? i_b : i_a;
      r_cnt <= CW'(XLEN);
    end else if (i_step) begin
      r_hi  <= o_hi_nxt;
      r_lo  <= o_lo_nxt;
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/ex_mdu.sv
// ex_mdu: multi-cycle RV M-extension unit in EX. Owns the IDLE/CALC/DONE
// control, special-case detection and sign fixup around md_iter.
module ex_mdu
  import ex_mdu_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter bit          SIGNED_FIX = 1'b1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            ex_md_valid,
  input  logic [2:0]      ex_md_op,
  input  logic [XLEN-1:0] ex_rfrdata1,
  input  logic [XLEN-1:0] ex_rfrdata2,
  input  logic            ex_flush,
  output logic            ex_md_stall,
  output logic            ex_md_done,
  output logic [XLEN-1:0] ex_md_result
);

  localparam int unsigned CW = $clog2(XLEN + 1);

  md_state_e         r_state, w_state_nxt;
  md_op_e            r_op;
  logic              r_neg_q;
  logic              r_neg_r;
  logic [XLEN-1:0]   r_result;

  md_op_e            w_op;
  logic              w_sa, w_sb;
  logic [XLEN-1:0]   w_mag_a, w_mag_b;
  logic              w_div0, w_ovf, w_special;
  logic [XLEN-1:0]   w_special_val;
  logic              w_start;
  logic              w_step;
  logic              w_calc_last;
  logic              w_stall;
  logic [XLEN-1:0]   w_hi_nxt, w_lo_nxt;
  logic [CW-1:0]     w_cnt;
  logic [2*XLEN-1:0] w_prod, w_prod_fx;
  logic [XLEN-1:0]   w_quo_fx, w_rem_fx;
  logic [XLEN-1:0]   w_calc_res;

  assign w_op    = md_op_e'(ex_md_op);
  assign w_sa    = SIGNED_FIX && op_a_signed(w_op) && ex_rfrdata1[XLEN-1];
  assign w_sb    = SIGNED_FIX && op_b_signed(w_op) && ex_rfrdata2[XLEN-1];
  assign w_mag_a = w_sa ? -ex_rfrdata1 : ex_rfrdata1;
  assign w_mag_b = w_sb ? -ex_rfrdata2 : ex_rfrdata2;

  assign w_div0    = op_is_div(w_op) && (ex_rfrdata2 == '0);
  assign w_ovf     = SIGNED_FIX && (w_op == OP_DIV || w_op == OP_REM) &&
                     (ex_rfrdata1 == {1'b1, {(XLEN-1){1'b0}}}) && (ex_rfrdata2 == '1);
  assign w_special = w_div0 | w_ovf;

  always_comb begin
    w_special_val = '0;
    if (w_div0)
      w_special_val = op_is_rem(w_op) ? ex_rfrdata1 : '1;
    else if (w_ovf)
      w_special_val = op_is_rem(w_op) ? '0 : ex_rfrdata1;
  end

  assign w_start     = (r_state == S_IDLE) && ex_md_valid && !ex_flush;
  assign w_step      = (r_state == S_CALC) && !ex_flush;
  assign w_calc_last = w_step && (w_cnt == CW'(1));

  md_iter #(
    .XLEN (XLEN),
    .CW   (CW)
  ) u_iter (
    .clk      (clk),
    .rstn     (rstn),
    .i_load   (w_start && !w_special),
    .i_div    (op_is_div(w_op)),
    .i_step   (w_step),
    .i_a      (w_mag_a),
    .i_b      (w_mag_b),
    .o_hi_nxt (w_hi_nxt),
    .o_lo_nxt (w_lo_nxt),
    .o_cnt    (w_cnt)
  );

  // Fixup reads the post-step values so the last iteration and the result
  // register update share one edge.
  always_comb begin
    w_prod    = {w_hi_nxt, w_lo_nxt};
    w_prod_fx = r_neg_q ? -w_prod : w_prod;
    w_quo_fx  = r_neg_q ? -w_lo_nxt : w_lo_nxt;
    w_rem_fx  = r_neg_r ? -w_hi_nxt : w_hi_nxt;
    w_calc_res = '0;
    case (r_op)
      OP_MUL:                        w_calc_res = w_prod_fx[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  w_calc_res = w_prod_fx[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               w_calc_res = w_quo_fx;
      OP_REM, OP_REMU:               w_calc_res = w_rem_fx;
      default:                       w_calc_res = '0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_stall = ex_md_valid && !ex_flush;
        if (w_start)
          w_state_nxt = w_special ? S_DONE : S_CALC;
      end
      S_CALC: begin
        w_stall = 1'b1;
        if (ex_flush)
          w_state_nxt = S_IDLE;
        else if (w_calc_last)
          w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= S_IDLE;
      r_op     <= OP_MUL;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_op    <= w_op;
        r_neg_q <= w_sa ^ w_sb;
        r_neg_r <= w_sa;
      end
      if (w_start && w_special)
        r_result <= w_special_val;
      else if (w_calc_last)
        r_result <= w_calc_res;
    end
  end

  assign ex_md_stall  = rstn && w_stall;
  assign ex_md_done   = (r_state == S_DONE) && !ex_flush;
  assign ex_md_result = r_result;

endmodule

// File: doc/ex_mdu.md
EX_MDU -- requirements
Module: ex_mdu

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; legal values 8..64, even.
REQ-002 Parameter SIGNED_FIX, default 1, 1 = support signed ops (MULH/MULHSU/DIV/REM); 0 = signed opcodes execute as unsigned.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rstn  input  1  asynchronous, active-low reset.
REQ-005 ex_md_valid  input  1  M-extension instruction present in EX, held stable while ex_md_stall=1.
REQ-006 ex_md_op  input  3  funct3: MUL=000 MULH=001 MULHSU=010 MULHU=011 DIV=100 DIVU=101 REM=110 REMU=111.
REQ-007 ex_rfrdata1  input  XLEN  operand A (dividend/multiplicand).
REQ-008 ex_rfrdata2  input  XLEN  operand B (divisor/multiplier).
REQ-009 ex_flush  input  1  kill in-flight operation (branch taken / exception).
REQ-010 ex_md_stall  output  1  hold IF/ID/EX pipeline registers.
REQ-011 ex_md_done  output  1  one-cycle pulse, ex_md_result valid.
REQ-012 ex_md_result  output  XLEN  registered result.

Function
REQ-013 FSM states IDLE, CALC, DONE; encoding 2 bits.
REQ-014 IDLE: ex_md_stall = ex_md_valid & ~ex_flush (combinational); on valid & ~flush latch operands/op, load counter = XLEN, go CALC.
REQ-015 Special cases detected in IDLE go directly to DONE: divisor 0 -> DIV/DIVU quotient all-ones, REM/REMU result = A; signed overflow (A = most-negative, B = -1) -> DIV result = A, REM result = 0.
REQ-016 CALC: one radix-2 iteration per cycle (shift-add multiply on 2*XLEN product; restoring divide); counter decrements; at counter = 1 go DONE; ex_md_stall = 1.
REQ-017 Signed ops: operands converted to magnitude at accept; sign fixup applied on CALC->DONE edge (quotient sign = sA^sB, remainder sign = sA, product sign = sA^sB; MULHSU treats B unsigned).
REQ-018 Result select: MUL low XLEN, MULH* high XLEN, DIV*/REM* quotient/remainder.
REQ-019 DONE: ex_md_done = 1, ex_md_stall = 0, ex_md_result valid; unconditional transition to IDLE (ex_md_valid ignored in DONE, belongs to same instruction).
REQ-020 Latency: normal op done XLEN+1 cycles after first valid cycle; special case done 1 cycle after; back-to-back op accepted in IDLE cycle following DONE.
REQ-021 ex_flush in any state: next edge -> IDLE, no ex_md_done, ex_md_result unchanged; flush in IDLE blocks start.
REQ-022 ex_md_result holds last value until next DONE.
REQ-023 All internal arithmetic in XLEN+1 (divide) / 2*XLEN (multiply) bits; no truncation before result select.

Reset
REQ-024 rstn low: state IDLE, counter 0, ex_md_result 0, ex_md_done 0, operand registers 0, asynchronously.
REQ-025 ex_md_stall = 0 during reset regardless of ex_md_valid.
REQ-026 Reset mid-CALC aborts operation; no done pulse after release.

Structure
REQ-027 Opcode encodings and FSM state constants live in ctrl_encode_def.vh alongside existing NPC/ALU defines.
REQ-028 Iterative datapath is one sub-module md_iter (shift/add/subtract step, counter); FSM, special-case detect, sign fixup in ex_mdu.
REQ-029 Counter width clog2(XLEN+1).

Verification
REQ-030 XLEN=32, MUL 7*6 -> done at cycle 33, result 42; stall high cycles 0..32.
REQ-031 MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU -1*2 -> 0xFFFFFFFF.
REQ-032 DIV -7/2 -> 0xFFFFFFFD, REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14, REMU -> 2.
REQ-033 DIV x/0 -> 0xFFFFFFFF in 1 cycle; REM 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000, REM -> 0.
REQ-034 Flush at CALC cycle 10 -> IDLE next edge, no done, result keeps previous value; new op accepted next cycle.
REQ-035 rstn low at CALC cycle 5 -> stall 0, result 0 immediately; XLEN=16 regression repeats REQ-030..033 scaled.
